// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and default sizes for the UART transmit arbiter
package uart_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } arb_state_e;

  localparam int N_REQ_DEF  = 2;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART handshake bundle for uart_tx_arbiter
//   master: requesters + UART (drive req_valid/req_data/req_last, uart_busy)
//   slave : arbiter (drives req_ready, grant, uart_data, uart_start, timeout_flag)
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = uart_arb_pkg::N_REQ_DEF,
  parameter int DATA_W = uart_arb_pkg::DATA_W_DEF
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       uart_data;
  logic                    uart_start;
  logic                    uart_busy;
  logic                    timeout_flag;

  modport master (
    output req_valid, req_data, req_last, uart_busy,
    input  req_ready, grant, uart_data, uart_start, timeout_flag
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_busy,
    output req_ready, grant, uart_data, uart_start, timeout_flag
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin search from a start pointer
//   i_valid  : request vector
//   i_ptr    : index searched first, search wraps modulo N
//   o_onehot : one-hot winner (zero when nothing valid)
//   o_idx    : winner index
//   o_any    : any request valid
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_valid[(int'(i_ptr) + k) % N]) begin
        o_any = 1'b1;
        o_onehot[(int'(i_ptr) + k) % N] = 1'b1;
        o_idx = PW'((int'(i_ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-granular round-robin sharing of one UART transmitter
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : uart_tx_arbiter_if.slave (requester byte streams, UART start/busy)
//   Optional ARB_TIMEOUT_EN: forced release of an owner idle mid-frame for TIMEOUT_CYC cycles
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             nrst,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  arb_state_e        r_state, w_state;
  logic [N_REQ-1:0]  r_grant, w_grant;
  logic [N_REQ-1:0]  r_ready, w_ready;
  logic [PW-1:0]     r_ptr, w_ptr;
  logic [PW-1:0]     r_owner, w_owner;
  logic              r_last, w_last;
  logic [DATA_W-1:0] r_data, w_data;
  logic              r_start, w_start;

  logic [N_REQ-1:0]  w_pick_oh;
  logic [PW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic              w_own_valid;
  logic              w_own_last;
  logic [DATA_W-1:0] w_own_data;
  logic [PW-1:0]     w_ptr_inc;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_tflag, w_tflag;
`endif

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .i_valid  (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_own_valid = bus.req_valid[r_owner];
  assign w_own_last  = bus.req_last[r_owner];
  assign w_own_data  = bus.req_data[int'(r_owner)*DATA_W +: DATA_W];
  // Pointer moves one past the owner so it becomes lowest priority next round
  assign w_ptr_inc   = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_last  = r_last;
    w_data  = r_data;
    w_start = 1'b0;
    w_ready = '0;
`ifdef ARB_TIMEOUT_EN
    w_cnt   = r_cnt;
    w_tflag = r_tflag;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant = w_pick_oh;
          w_owner = w_pick_idx;
          w_state = LOAD;
        end
      end
      LOAD: begin
        if (w_own_valid && !bus.uart_busy) begin
          w_data           = w_own_data;
          w_start          = 1'b1;
          w_ready[r_owner] = 1'b1;
          w_last           = w_own_last;
          w_state          = SETTLE;
`ifdef ARB_TIMEOUT_EN
          w_cnt            = '0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        // Only cycles with the owner silent count; a busy UART is not the owner's fault
        else if (!w_own_valid) begin
          if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
            w_cnt   = '0;
            w_grant = '0;
            w_ptr   = w_ptr_inc;
            w_tflag = 1'b1;
            w_state = IDLE;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
`endif
      end
      // Give the UART one cycle to raise busy before DRAIN samples it
      SETTLE: w_state = DRAIN;
      DRAIN: begin
        if (!bus.uart_busy) begin
          if (r_last) begin
            w_grant = '0;
            w_ptr   = w_ptr_inc;
            w_state = IDLE;
          end else begin
            w_state = LOAD;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ready <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_start <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_tflag <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_ready <= w_ready;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_last  <= w_last;
      r_data  <= w_data;
      r_start <= w_start;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= w_cnt;
      r_tflag <= w_tflag;
`endif
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.grant      = r_grant;
  assign bus.uart_data  = r_data;
  assign bus.uart_start = r_start;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_flag = r_tflag;
`else
  assign bus.timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with UART and requester models
module tb_uart_tx_arbiter;
  localparam int N        = 2;
  localparam int W        = 8;
  localparam int TO       = 16;
  localparam int BUSY_LEN = 10;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // {last, byte}: drv_q is what each requester still has to present,
  // exp_q is what the UART must still receive from it, in order
  logic [W:0] drv_q [N][$];
  logic [W:0] exp_q [N][$];
  logic [N-1:0] stall = '0;
  logic force_busy = 1'b0;
  logic tb_busy    = 1'b0;
  int   model_cnt  = 0;

  assign bus.uart_busy = tb_busy;

  // scoreboard state
  int         m_owner  = -1;
  int         m_ptr    = 0;
  bit         m_done   = 1'b0;
  bit         m_tflag  = 1'b0;
  int         n_starts = 0;
  logic       prev_busy  = 1'b0;
  logic [N-1:0] prev_valid = '0;
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_expect(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic push_byte(input int r, input logic [W-1:0] d, input logic last);
    drv_q[r].push_back({last, d});
    exp_q[r].push_back({last, d});
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (drv_q[0].size() == 0 && drv_q[1].size() == 0 && bus.grant == '0 && !tb_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle_reached"}, ok, 1'b1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (n_starts >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check("start_wait", ok, 1'b1);
  endtask

  // requesters: update right after each rising edge, pop on ready
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        bus.req_valid[i] = (drv_q[i].size() > 0) && !stall[i];
        if (drv_q[i].size() > 0) begin
          bus.req_data[i*W +: W] = drv_q[i][0][W-1:0];
          bus.req_last[i]        = drv_q[i][0][W];
        end
      end
    end
  end

  // UART model and scoreboard monitor on the falling edge
  initial begin
    forever begin
      logic [N-1:0] exp_ready;
      int           e;
      @(negedge clk);
      if (nrst) begin
        if (prev_grant == '0 && bus.grant != '0) begin
          e = rr_expect(prev_valid, m_ptr);
          check("grant_pick", bus.grant, (e < 0) ? '0 : (64'd1 << e));
          m_owner = e;
          m_done  = 1'b0;
        end else if (prev_grant != '0 && bus.grant == '0) begin
`ifdef ARB_TIMEOUT_EN
          if (!m_done && m_owner >= 0) begin
            m_tflag = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            exp_q[m_owner].delete();
          end
`else
          check("release_after_last", m_done, 1'b1);
`endif
          m_owner = -1;
        end else if (prev_grant != '0) begin
          check("grant_hold", bus.grant, prev_grant);
        end
        check("timeout_flag", bus.timeout_flag, m_tflag);

        exp_ready = (bus.uart_start && m_owner >= 0) ? N'(1 << m_owner) : '0;
        check("req_ready", bus.req_ready, exp_ready);

        if (bus.uart_start) begin
          n_starts++;
          check("start_while_busy", prev_busy, 1'b0);
          check("start_owner", (m_owner >= 0 && !m_done), 1'b1);
          if (m_owner >= 0 && !m_done) begin
            if (exp_q[m_owner].size() == 0) begin
              check("unexpected_byte", bus.uart_data, 64'hDEAD);
            end else begin
              logic [W:0] x;
              x = exp_q[m_owner].pop_front();
              check("uart_data", bus.uart_data, x[W-1:0]);
              if (x[W]) begin
                m_done = 1'b1;
                m_ptr  = (m_owner + 1) % N;
              end
            end
          end
        end
      end
      if (bus.uart_start) model_cnt = BUSY_LEN;
      else if (model_cnt > 0) model_cnt--;
      tb_busy    = (model_cnt > 0) || force_busy;
      prev_busy  = tb_busy;
      prev_valid = bus.req_valid;
      prev_grant = bus.grant;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int len;
    // reset state
    #12;
    check("rst_grant", bus.grant, '0);
    check("rst_ready", bus.req_ready, '0);
    check("rst_start", bus.uart_start, 1'b0);
    check("rst_data", bus.uart_data, '0);
    check("rst_tflag", bus.timeout_flag, 1'b0);
    @(posedge clk); #2 nrst = 1'b1;

    // single requester frame and first-byte latency
    @(posedge clk); #2;
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h0D, 1'b0);
    push_byte(0, 8'h0A, 1'b1);
    @(posedge clk);
    @(posedge clk); #3;
    check("lat_grant", bus.grant, 2'b01);
    check("lat_no_start_yet", bus.uart_start, 1'b0);
    @(posedge clk); #3;
    check("lat_start", bus.uart_start, 1'b1);
    check("lat_data", bus.uart_data, 8'h41);
    wait_idle(300, "single");
    check("single_grant_clear", bus.grant, '0);
    check("single_all_sent", exp_q[0].size(), 0);

    // random contention
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < N; r++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) push_byte(r, W'($urandom), b == len - 1);
      end
    end
    wait_idle(3000, "contention");
    check("contention_sent0", exp_q[0].size(), 0);
    check("contention_sent1", exp_q[1].size(), 0);

    // UART busy held high while an owner waits in LOAD
    @(posedge clk); #2;
    force_busy = 1'b1;
    base = n_starts;
    push_byte(0, 8'h5A, 1'b1);
    repeat (20) @(posedge clk);
    check("busy_no_start", n_starts, base);
    #2 force_busy = 1'b0;
    repeat (30) @(posedge clk);
    check("busy_one_start", n_starts, base + 1);
    wait_idle(300, "busy");

`ifndef ARB_TIMEOUT_EN
    // owner stalls mid-frame; other requester must be ignored
    base = n_starts;
    push_byte(1, 8'hA1, 1'b0);
    push_byte(1, 8'hA2, 1'b0);
    push_byte(1, 8'hA3, 1'b1);
    wait_starts(base + 1, 100);
    stall[1] = 1'b1;
    push_byte(0, 8'hB1, 1'b0);
    push_byte(0, 8'hB2, 1'b1);
    repeat (50) @(posedge clk);
    check("stall_no_start", n_starts, base + 1);
    check("stall_grant", bus.grant, 2'b10);
    stall[1] = 1'b0;
    wait_idle(500, "stall");
    check("stall_sent0", exp_q[0].size(), 0);
    check("stall_sent1", exp_q[1].size(), 0);
`else
    // owner idles mid-frame long enough for forced release
    base = n_starts;
    push_byte(1, 8'hA1, 1'b0);
    push_byte(1, 8'hA2, 1'b1);
    wait_starts(base + 1, 100);
    stall[1] = 1'b1;
    push_byte(0, 8'hB1, 1'b1);
    repeat (60) @(posedge clk);
    check("to_flag", bus.timeout_flag, 1'b1);
    drv_q[1].delete();
    stall[1] = 1'b0;
    wait_idle(500, "timeout");
    check("to_flag_sticky", bus.timeout_flag, 1'b1);
    check("to_pending_served", exp_q[0].size(), 0);
`endif

    // reset in DRAIN of byte 2 of 4, then both requesters contend from pointer 0
    @(posedge clk);
    base = n_starts;
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b0);
    push_byte(0, 8'h44, 1'b1);
    wait_starts(base + 2, 200);
    repeat (4) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mrst_grant", bus.grant, '0);
    check("mrst_ready", bus.req_ready, '0);
    check("mrst_start", bus.uart_start, 1'b0);
    check("mrst_tflag", bus.timeout_flag, 1'b0);
    for (int r = 0; r < N; r++) begin
      drv_q[r].delete();
      exp_q[r].delete();
    end
    stall   = '0;
    m_owner = -1;
    m_ptr   = 0;
    m_done  = 1'b0;
    m_tflag = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    push_byte(1, 8'hC1, 1'b1);
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b0);
    push_byte(0, 8'h44, 1'b1);
    nrst = 1'b1;
    wait_idle(500, "after_reset");
    check("after_reset_sent0", exp_q[0].size(), 0);
    check("after_reset_sent1", exp_q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between N_REQ byte-stream requesters, for example the PUF response streamer and a status/debug message source.
- Arbitrates round-robin at frame granularity. Once granted, a requester owns the UART until it presents a byte with last=1.
- Sequences each byte into the UART start/busy handshake and returns a one-cycle ready to the owner.
- Sits between the requester FSMs and the UART transmitter in the top-level design.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width to the UART
TIMEOUT_CYC, 65535, idle cycles allowed mid-frame before forced release (used only with the optional feature)

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  per-requester byte valid
req_data  in  N_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  N_REQ  byte is the final byte of the frame
req_ready  out  N_REQ  one-cycle accept pulse to the owner
grant  out  N_REQ  one-hot current owner; all zero when no owner
uart_data  out  DATA_W  registered byte to the UART
uart_start  out  1  one-cycle transmit pulse
uart_busy  in  1  UART busy
timeout_flag  out  1  sticky forced-release indicator (tied 0 unless ARB_TIMEOUT_EN is defined)

Behaviour:
- Reset values: all outputs are 0, state=IDLE, rr pointer=0.
- Outputs: every output is registered. req_ready and uart_start are single-cycle pulses.

State machine:
- IDLE:
  - If any req_valid is high, pick the first valid requester searching from the rr pointer upward, wrapping modulo N_REQ.
  - Set its grant bit, then go to LOAD.
  - grant becomes visible the cycle after the arbitration decision.
- LOAD: when the owner's req_valid=1 and uart_busy=0, in the same cycle:
  - uart_data <= owner byte
  - uart_start <= 1
  - req_ready[owner] <= 1
  - latch last_q <= req_last[owner]
  - go to SETTLE.
- SETTLE: one wait cycle so the UART raises busy; then go to DRAIN.
- DRAIN: wait for uart_busy=0, then:
  - if last_q=1: clear grant, set rr pointer <= owner+1 (mod N_REQ), go to IDLE.
  - else: go to LOAD.

Throughput and latency:
- Byte throughput: one byte per UART frame plus 3 clk overhead.
- First-byte latency from req_valid (arbiter idle): 2 clk to uart_start.

Rules:
- A requester holds req_valid/req_data/req_last stable until its ready pulse.
- Bytes from non-owners are never accepted. Their req_ready stays 0.
- Simultaneous requests are resolved by the rr pointer only. The pointer advances only on frame end or forced release.
- A requester that drops valid mid-frame keeps its grant; the arbiter waits in LOAD indefinitely unless the optional feature is enabled.
- nrst asserted mid-frame returns everything to reset values immediately. A UART byte already in flight completes inside the UART; the arbiter ignores it.
- If uart_busy is already high in LOAD, the arbiter stalls without pulsing uart_start.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - In LOAD, a counter (width $clog2(TIMEOUT_CYC+1)) counts cycles with the owner's req_valid=0.
  - When the count reaches TIMEOUT_CYC, clear grant, advance the rr pointer past the owner, set timeout_flag=1 (sticky until nrst), and go to IDLE.
  - The counter clears on every accepted byte.
- Undefined: no counter, timeout_flag tied 0, grant is held indefinitely.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, LOAD, SETTLE, DRAIN), 2-bit encoding
  - default N_REQ and DATA_W constants
- Sub-module rr_pick:
  - combinational round-robin search: inputs are the valid vector and the pointer; outputs are a one-hot pick and an index.
  - instanced once.
- Main module: FSM, data register, pointer and timeout counter.

Test Plan:
1. Single requester: req0 sends frame 0x41,0x42,0x0D,0x0A (last on 0x0A); UART model with 10-clk busy -> four uart_start pulses with bytes in order; grant=01 throughout; grant=00 after final DRAIN.
2. Contention: req0 and req1 both valid after reset, 2-byte frames -> req0 served first (pointer 0), then req1, then req0 again if still requesting; frames never interleave.
3. Mid-frame stall: req1 owner drops valid for 50 clk between bytes -> no uart_start during the gap, grant stays 10, req0's valid is ignored; without ARB_TIMEOUT_EN the frame resumes intact.
4. Busy already high: hold uart_busy=1 in LOAD for 20 clk -> no uart_start until busy falls, then exactly one pulse.
5. Reset mid-frame: assert nrst during DRAIN of byte 2 of 4 -> grant, req_ready, uart_start and state return to 0/IDLE; after release, req0 restarts from its first byte.
6. ARB_TIMEOUT_EN, TIMEOUT_CYC=16: owner idles 16 clk mid-frame -> grant clears, timeout_flag=1 and stays 1; pending requester granted next.
